ddr4_cmd_decoder: RTL
=====================

Name: ddr4_cmd_decoder

Overview:
- Front-end stage of the emulated DDR4 device. Sits directly upstream of the chip/bank-group array.
- Samples the raw DDR4 command/address pins each clock and decodes them into the 19-bit one-hot `commands` vector, bank-group/bank select and row/column address consumed by the chip model.
- Tracks CKE-based power states and the MR0 burst-length mode.
- Generates read/write data-window strobes aligned to CL/CWL.

Parameters:
- ADDRWIDTH, 17, row address width; address pin bus width.
- BANKGROUPS, 2, bank groups per chip.
- BANKSPERGROUP, 2, banks per group.
- COLS, 1024, columns per row; CADDRWIDTH = $clog2(COLS).
- CL, 11, read latency in clocks, valid range 2..31.
- CWL, 9, write latency in clocks, valid range 2..31.
- BGWIDTH / BAWIDTH are localparams: $clog2(BANKGROUPS) and $clog2(BANKSPERGROUP).

Ports:
- clk, in, 1, sole clock; everything on the rising edge.
- reset, in, 1, synchronous, active-high.
- cke, in, 1, clock enable pin.
- cs_n, in, 1, chip select (active low).
- act_n, in, 1, activate (active low).
- bg_in, in, BGWIDTH+1, bank-group pins.
- ba_in, in, BAWIDTH+1, bank pins.
- a, in, ADDRWIDTH, address pins; A16/A15/A14 double as RAS_n/CAS_n/WE_n.
- commands, out, 19, one-hot decoded command, registered.
- bg, out, BGWIDTH+1, registered bank group.
- ba, out, BAWIDTH+1, registered bank.
- row, out, ADDRWIDTH, registered row address.
- column, out, CADDRWIDTH, registered column address.
- rd_window, out, 1, read data burst active.
- wr_window, out, 1, write data burst active.
- pwr_state, out, 2, 0 = ACTIVE, 1 = PWRDN, 2 = SELFREF.
- illegal_cmd, out, 1, one-cycle pulse on an RFU encoding or a command while not ACTIVE.

Behaviour:
- Command bit indices: 0 MRS, 1 REF, 2 SRE, 3 SRX, 4 PRE, 5 PREA, 6 ACT, 7 WR, 8 WRS4, 9 WRS8, 10 WRA, 11 WRAS4, 12 WRAS8, 13 RD, 14 RDS4, 15 RDS8, 16 RDA, 17 RDAS4, 18 RDAS8.
- At most one bit is set per cycle. All-zero means no command.
- Reset values: all outputs 0, pwr_state=ACTIVE, cke_q=1, bl_mode=00, window shift registers cleared.
- Reset mid-burst kills both windows on the next edge.
- Decode applies only when cs_n=0 and state ACTIVE with cke=1:
  - act_n=0: ACT; row=a.
  - act_n=1, {A16,A15,A14} = LLL: MRS. If bg_in=0 and ba_in=0 (MR0), bl_mode <= a[1:0]. MRS to other registers is decoded but stored nowhere.
  - LLH: REF when cke_q=1 and cke=1. SRE when cke_q=1 and cke=0.
  - LHL: PRE if a[10]=0, PREA if a[10]=1.
  - HLL: write. HLH: read.
  - HHH: NOP, no bit. HHL: ZQ, no bit, not illegal. LHH: RFU, sets illegal_cmd.
- Read/write variant selection:
  - a[10]=1 selects the auto-precharge form.
  - bl_mode=00: plain form (BL8).
  - bl_mode=10: S4 form (BC4).
  - bl_mode=01 (on-the-fly): a[12]=1 selects S8, a[12]=0 selects S4.
  - bl_mode=11 is treated as 00.
- column <= a[CADDRWIDTH-1:0] on reads and writes. bg/ba register on every decoded command and hold otherwise.
- Latency: pins sampled at edge N appear on the outputs after edge N+1. commands is a single-cycle pulse.
- Power FSM (cke_q = previous cke):
  - ACTIVE→SELFREF on the SRE decode.
  - ACTIVE→PWRDN when cke falls with no REF.
  - SELFREF→ACTIVE on a cke rise with cs_n=1 or NOP; SRX pulses that cycle.
  - PWRDN→ACTIVE on a cke rise; no command bit.
  - In PWRDN/SELFREF, any cs_n=0 non-NOP encoding is ignored and pulses illegal_cmd.
  - A cke rise in SELFREF with a non-NOP command still exits and emits SRX, and also pulses illegal_cmd.
- Data windows:
  - Burst length in clocks: 4 for BL8 forms, 2 for BC4 forms.
  - A read emitted on commands at cycle T drives rd_window high for cycles T+CL .. T+CL+len-1. Writes use CWL and wr_window.
  - Implemented as per-cycle shift registers of depth 31+4; overlapping or back-to-back bursts OR together.
  - No collision checking.

Test Plan:
- Reset: hold reset 3 cycles with random pins → commands=0, pwr_state=0, windows 0. Release, drive ACT with bg_in=1, ba_in=0, a=0x1ABCD → one cycle later commands=0x00040 (bit 6), row=0x1ABCD, bg=1.
- MR0 on-the-fly: MRS with bg/ba=0, a=0x00001, then RD with a[12]=1, a[10]=0, a[9:0]=0x155 → bit 15 RDS8, column=0x155. rd_window high exactly 4 cycles starting CL=11 cycles after the pulse. Repeat with a[12]=0 → bit 14, window 2 cycles.
- Auto-precharge/PREA: WR with a[10]=1 under bl_mode=00 → bit 10 WRA, wr_window 4 cycles at +CWL=9. PRE with a[10]=1 → bit 5.
- Self-refresh: REF with cke 1→0 → bit 2 SRE, pwr_state=2. Issue RD while cke=0 → commands=0, illegal_cmd pulse. Raise cke with cs_n=1 → bit 3 SRX, pwr_state=0.
- Power-down: cke falls with NOP → pwr_state=1, no command. Raise cke → pwr_state=0, commands=0.
- Back-to-back reads 2 cycles apart in BL8 → rd_window contiguous for 6 cycles. RFU encoding (LHH) → illegal_cmd=1 for one cycle, commands=0.

Source files
------------

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command/address front end: samples the pins, decodes one-hot commands,
// tracks CKE power states and MR0 burst mode, and shapes CL/CWL data windows.
//   state      | meaning
//   ST_ACTIVE  | normal decode, cke high
//   ST_PWRDN   | precharge/active power-down, commands rejected
//   ST_SELFREF | self refresh, exits with SRX on cke rise
module ddr4_cmd_decoder #(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 2,
    parameter int BANKSPERGROUP = 2,
    parameter int COLS          = 1024,
    parameter int CL            = 11,
    parameter int CWL           = 9,
    localparam int CADDRWIDTH   = $clog2(COLS),
    localparam int BGWIDTH      = $clog2(BANKGROUPS),
    localparam int BAWIDTH      = $clog2(BANKSPERGROUP)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic                  cs_n,
    input  logic                  act_n,
    input  logic [BGWIDTH:0]      bg_in,
    input  logic [BAWIDTH:0]      ba_in,
    input  logic [ADDRWIDTH-1:0]  a,
    output logic [18:0]           commands,
    output logic [BGWIDTH:0]      bg,
    output logic [BAWIDTH:0]      ba,
    output logic [ADDRWIDTH-1:0]  row,
    output logic [CADDRWIDTH-1:0] column,
    output logic                  rd_window,
    output logic                  wr_window,
    output logic [1:0]            pwr_state,
    output logic                  illegal_cmd
);
    localparam int WDEPTH = 35;

    typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_PWRDN = 2'd1, ST_SELFREF = 2'd2} pwr_e;
    typedef enum logic [1:0] {F_BL8 = 2'd0, F_BC4 = 2'd1, F_S8 = 2'd2} form_e;

    // pin sampling stage
    logic                  cke_p_q, cs_n_p_q, act_n_p_q, cke_q;
    logic [BGWIDTH:0]      bg_p_q;
    logic [BAWIDTH:0]      ba_p_q;
    logic [ADDRWIDTH-1:0]  a_p_q;

    pwr_e                  state_q, state_d;
    logic [18:0]           cmd_q, cmd_d;
    logic                  ill_q, ill_d;
    logic [1:0]            bl_mode_q, bl_mode_d;
    logic [BGWIDTH:0]      bg_q, bg_d;
    logic [BAWIDTH:0]      ba_q, ba_d;
    logic [ADDRWIDTH-1:0]  row_q, row_d;
    logic [CADDRWIDTH-1:0] col_q, col_d;
    logic [WDEPTH-1:0]     rd_sr_q, rd_sr_d, wr_sr_q, wr_sr_d;

    form_e                 form;
    logic [2:0]            rcw;
    logic [4:0]            rw_off;
    logic [WDEPTH-1:0]     burst_bits;
    logic                  is_nop, dec_hit, rd_hit, wr_hit;

    assign rcw    = a_p_q[16:14];
    assign is_nop = act_n_p_q && (rcw == 3'b111);

    // bl_mode 11 falls through to fixed BL8
    always_comb begin
        form = F_BL8;
        case (bl_mode_q)
            2'b10:   form = F_BC4;
            2'b01:   form = a_p_q[12] ? F_S8 : F_BC4;
            default: form = F_BL8;
        endcase
    end

    assign rw_off     = 5'(form) + (a_p_q[10] ? 5'd3 : 5'd0);
    assign burst_bits = (form == F_BC4) ? WDEPTH'(3) : WDEPTH'(15);

    always_comb begin
        state_d   = state_q;
        cmd_d     = '0;
        ill_d     = 1'b0;
        bl_mode_d = bl_mode_q;
        bg_d      = bg_q;
        ba_d      = ba_q;
        row_d     = row_q;
        col_d     = col_q;
        dec_hit   = 1'b0;
        rd_hit    = 1'b0;
        wr_hit    = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (!cke_p_q) begin
                    if (cke_q && !cs_n_p_q && act_n_p_q && rcw == 3'b001) begin
                        cmd_d[2] = 1'b1;
                        dec_hit  = 1'b1;
                        state_d  = ST_SELFREF;
                    end else begin
                        state_d = ST_PWRDN;
                    end
                end else if (!cs_n_p_q) begin
                    dec_hit = 1'b1;
                    if (!act_n_p_q) begin
                        cmd_d[6] = 1'b1;
                        row_d    = a_p_q;
                    end else begin
                        case (rcw)
                            3'b000: begin
                                cmd_d[0] = 1'b1;
                                if (bg_p_q == '0 && ba_p_q == '0) bl_mode_d = a_p_q[1:0];
                            end
                            3'b001: begin
                                if (cke_q) cmd_d[1] = 1'b1;
                                else dec_hit = 1'b0;
                            end
                            3'b010: begin
                                if (a_p_q[10]) cmd_d[5] = 1'b1;
                                else cmd_d[4] = 1'b1;
                            end
                            3'b100: begin
                                cmd_d  = 19'd1 << (5'd7 + rw_off);
                                col_d  = a_p_q[CADDRWIDTH-1:0];
                                wr_hit = 1'b1;
                            end
                            3'b101: begin
                                cmd_d  = 19'd1 << (5'd13 + rw_off);
                                col_d  = a_p_q[CADDRWIDTH-1:0];
                                rd_hit = 1'b1;
                            end
                            3'b011: begin
                                ill_d   = 1'b1;
                                dec_hit = 1'b0;
                            end
                            default: dec_hit = 1'b0;
                        endcase
                    end
                end
            end
            ST_PWRDN, ST_SELFREF: begin
                if (!cs_n_p_q && !is_nop) ill_d = 1'b1;
                if (cke_p_q) begin
                    state_d = ST_ACTIVE;
                    if (state_q == ST_SELFREF) cmd_d[3] = 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
        if (dec_hit) begin
            bg_d = bg_p_q;
            ba_d = ba_p_q;
        end
        rd_sr_d = (rd_sr_q >> 1) | (rd_hit ? (burst_bits << CL) : '0);
        wr_sr_d = (wr_sr_q >> 1) | (wr_hit ? (burst_bits << CWL) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cke_p_q   <= 1'b1;
            cke_q     <= 1'b1;
            cs_n_p_q  <= 1'b1;
            act_n_p_q <= 1'b1;
            bg_p_q    <= '0;
            ba_p_q    <= '0;
            a_p_q     <= '0;
            state_q   <= ST_ACTIVE;
            cmd_q     <= '0;
            ill_q     <= 1'b0;
            bl_mode_q <= 2'b00;
            bg_q      <= '0;
            ba_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rd_sr_q   <= '0;
            wr_sr_q   <= '0;
        end else begin
            cke_p_q   <= cke;
            cke_q     <= cke_p_q;
            cs_n_p_q  <= cs_n;
            act_n_p_q <= act_n;
            bg_p_q    <= bg_in;
            ba_p_q    <= ba_in;
            a_p_q     <= a;
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            ill_q     <= ill_d;
            bl_mode_q <= bl_mode_d;
            bg_q      <= bg_d;
            ba_q      <= ba_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rd_sr_q   <= rd_sr_d;
            wr_sr_q   <= wr_sr_d;
        end
    end

    assign commands    = cmd_q;
    assign illegal_cmd = ill_q;
    assign pwr_state   = state_q;
    assign bg          = bg_q;
    assign ba          = ba_q;
    assign row         = row_q;
    assign column      = col_q;
    assign rd_window   = rd_sr_q[0];
    assign wr_window   = wr_sr_q[0];
endmodule
